// File: rtl/cflog_if.sv
// CFLog producer bus: committed-transfer handshake from the CPU monitor and
// the hardware write port toward the attestation metadata memory.
interface cflog_if;
    logic        cf_valid;
    logic        cf_ready;
    logic [15:0] cf_src;
    logic [15:0] cf_dest;
    logic [15:0] cflow_src;
    logic [15:0] cflow_dest;
    logic        cflow_hw_wen;
    logic [15:0] cflow_logs_ptr;

    modport master (
        output cf_valid,
        output cf_src,
        output cf_dest,
        input  cf_ready,
        input  cflow_src,
        input  cflow_dest,
        input  cflow_hw_wen,
        input  cflow_logs_ptr
    );

    modport slave (
        input  cf_valid,
        input  cf_src,
        input  cf_dest,
        output cf_ready,
        output cflow_src,
        output cflow_dest,
        output cflow_hw_wen,
        output cflow_logs_ptr
    );
endinterface

// File: rtl/cflog_writer.sv
// CFLog writer: appends committed non-sequential transfers to the control-flow
// log while the attested region runs, folding repeated identical transfers
// (tight loops) into a (CNT_MARK, count) entry.
//
// state  | meaning
// IDLE   | waiting for a transfer landing on er_min; everything else ignored
// ACTIVE | logging transfers and counting repeats of the last logged pair
// FLUSH  | counter entry was just written; write the held pending pair now
// DONE   | exit transfer logged; transfers ignored until log_clear
module cflog_writer #(
    parameter int          LOG_WORDS = 128,
    parameter logic [15:0] CNT_MARK  = 16'hFFFF
) (
    input  logic        mclk,
    input  logic        puc_rst,
    cflog_if.slave      cf_bus,
    input  logic [15:0] er_min,
    input  logic [15:0] er_max,
    input  logic        log_clear,
    output logic        log_active,
    output logic        log_done,
    output logic        log_overflow
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    localparam logic [15:0] LOG_LIMIT = 16'(LOG_WORDS);
    // Counter entries saturate one below CNT_MARK so a count never looks like a tag.
    localparam logic [15:0] REP_SAT   = 16'hFFFE;

    state_t      state, state_nxt;
    logic [15:0] rep_cnt, rep_nxt;
    logic [15:0] last_src, last_dest, last_src_nxt, last_dest_nxt;
    logic        last_vld, last_vld_nxt;
    logic [15:0] pend_src, pend_dest, pend_src_nxt, pend_dest_nxt;
    logic        wr_req;
    logic [15:0] wr_src, wr_dest;
    logic        done_set;
    logic        accept;
    logic        pair_match;

    assign cf_bus.cf_ready = (state != FLUSH);
    assign log_active      = (state == ACTIVE) || (state == FLUSH);
    assign accept          = cf_bus.cf_valid && cf_bus.cf_ready;
    assign pair_match      = last_vld && (cf_bus.cf_src == last_src)
                                      && (cf_bus.cf_dest == last_dest);

    // Next-state and entry selection; fullness is handled at the write itself.
    always_comb begin
        state_nxt     = state;
        rep_nxt       = rep_cnt;
        last_src_nxt  = last_src;
        last_dest_nxt = last_dest;
        last_vld_nxt  = last_vld;
        pend_src_nxt  = pend_src;
        pend_dest_nxt = pend_dest;
        wr_req        = 1'b0;
        wr_src        = 16'h0000;
        wr_dest       = 16'h0000;
        done_set      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (cf_bus.cf_dest == er_min)) begin
                    wr_req        = 1'b1;
                    wr_src        = cf_bus.cf_src;
                    wr_dest       = cf_bus.cf_dest;
                    last_src_nxt  = cf_bus.cf_src;
                    last_dest_nxt = cf_bus.cf_dest;
                    last_vld_nxt  = 1'b1;
                    state_nxt     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (pair_match) begin
                        if (rep_cnt == REP_SAT - 16'd1) begin
                            wr_req  = 1'b1;
                            wr_src  = CNT_MARK;
                            wr_dest = REP_SAT;
                            rep_nxt = 16'h0000;
                        end else begin
                            rep_nxt = rep_cnt + 16'd1;
                        end
                    end else if (rep_cnt == 16'h0000) begin
                        wr_req        = 1'b1;
                        wr_src        = cf_bus.cf_src;
                        wr_dest       = cf_bus.cf_dest;
                        last_src_nxt  = cf_bus.cf_src;
                        last_dest_nxt = cf_bus.cf_dest;
                        if (cf_bus.cf_src == er_max) begin
                            done_set  = 1'b1;
                            state_nxt = DONE;
                        end
                    end else begin
                        wr_req        = 1'b1;
                        wr_src        = CNT_MARK;
                        wr_dest       = rep_cnt;
                        pend_src_nxt  = cf_bus.cf_src;
                        pend_dest_nxt = cf_bus.cf_dest;
                        state_nxt     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                wr_req        = 1'b1;
                wr_src        = pend_src;
                wr_dest       = pend_dest;
                rep_nxt       = 16'h0000;
                last_src_nxt  = pend_src;
                last_dest_nxt = pend_dest;
                if (pend_src == er_max) begin
                    done_set  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = ACTIVE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, tracking registers and the write port; a full log drops the entry.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state                 <= IDLE;
            rep_cnt               <= 16'h0000;
            last_src              <= 16'h0000;
            last_dest             <= 16'h0000;
            last_vld              <= 1'b0;
            pend_src              <= 16'h0000;
            pend_dest             <= 16'h0000;
            cf_bus.cflow_src      <= 16'h0000;
            cf_bus.cflow_dest     <= 16'h0000;
            cf_bus.cflow_hw_wen   <= 1'b0;
            cf_bus.cflow_logs_ptr <= 16'h0000;
            log_done              <= 1'b0;
            log_overflow          <= 1'b0;
        end else if (log_clear) begin
            state                 <= IDLE;
            rep_cnt               <= 16'h0000;
            last_src              <= 16'h0000;
            last_dest             <= 16'h0000;
            last_vld              <= 1'b0;
            pend_src              <= 16'h0000;
            pend_dest             <= 16'h0000;
            cf_bus.cflow_src      <= 16'h0000;
            cf_bus.cflow_dest     <= 16'h0000;
            cf_bus.cflow_hw_wen   <= 1'b0;
            cf_bus.cflow_logs_ptr <= 16'h0000;
            log_done              <= 1'b0;
            log_overflow          <= 1'b0;
        end else begin
            state               <= state_nxt;
            rep_cnt             <= rep_nxt;
            last_src            <= last_src_nxt;
            last_dest           <= last_dest_nxt;
            last_vld            <= last_vld_nxt;
            pend_src            <= pend_src_nxt;
            pend_dest           <= pend_dest_nxt;
            cf_bus.cflow_hw_wen <= 1'b0;
            if (wr_req) begin
                if (cf_bus.cflow_logs_ptr < LOG_LIMIT) begin
                    cf_bus.cflow_src      <= wr_src;
                    cf_bus.cflow_dest     <= wr_dest;
                    cf_bus.cflow_hw_wen   <= 1'b1;
                    cf_bus.cflow_logs_ptr <= cf_bus.cflow_logs_ptr + 16'd2;
                end else begin
                    log_overflow <= 1'b1;
                end
            end
            if (done_set) begin
                log_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer: a vector table for the main flow plus
// hand-written sequences for log-full, counter-with-one-slot and reset-in-FLUSH.
module tb_cflog_writer;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        log_clear;
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic        log_active;
    logic        log_done;
    logic        log_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    cflog_if bus ();

    cflog_writer #(
        .LOG_WORDS (128),
        .CNT_MARK  (16'hFFFF)
    ) dut (
        .mclk         (mclk),
        .puc_rst      (puc_rst),
        .cf_bus       (bus),
        .er_min       (er_min),
        .er_max       (er_max),
        .log_clear    (log_clear),
        .log_active   (log_active),
        .log_done     (log_done),
        .log_overflow (log_overflow)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        valid;
        logic [15:0] src;
        logic [15:0] dest;
        logic        clr;
        logic        wen;
        logic        rdy;
        logic        act;
        logic        done;
        logic        ovf;
        logic [15:0] esrc;
        logic [15:0] edest;
        logic [15:0] eptr;
    } vec_t;

    vec_t vt[22];

    // {wen, ready, active, done, overflow, src, dest, ptr}
    function automatic logic [52:0] snap();
        return {bus.cflow_hw_wen, bus.cf_ready, log_active, log_done, log_overflow,
                bus.cflow_src, bus.cflow_dest, bus.cflow_logs_ptr};
    endfunction

    function automatic logic [52:0] pack(logic wen, logic rdy, logic act, logic done,
                                         logic ovf, logic [15:0] s, logic [15:0] d,
                                         logic [15:0] p);
        return {wen, rdy, act, done, ovf, s, d, p};
    endfunction

    function automatic vec_t mk(logic valid, logic [15:0] src, logic [15:0] dest, logic clr,
                                logic wen, logic rdy, logic act, logic done, logic ovf,
                                logic [15:0] esrc, logic [15:0] edest, logic [15:0] eptr);
        vec_t v;
        v.valid = valid; v.src = src; v.dest = dest; v.clr = clr;
        v.wen = wen; v.rdy = rdy; v.act = act; v.done = done; v.ovf = ovf;
        v.esrc = esrc; v.edest = edest; v.eptr = eptr;
        return v;
    endfunction

    task automatic check(string name, logic [52:0] act, logic [52:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got wen/rdy/act/done/ovf=%b src=%h dest=%h ptr=%h, expected %b src=%h dest=%h ptr=%h",
                     name, act[52:48], act[47:32], act[31:16], act[15:0],
                     exp[52:48], exp[47:32], exp[31:16], exp[15:0]);
        end
    endtask

    // Present inputs for one cycle, then sample 1 time unit after the edge.
    task automatic cyc(logic valid, logic [15:0] src, logic [15:0] dest, logic clr);
        bus.cf_valid = valid;
        bus.cf_src   = src;
        bus.cf_dest  = dest;
        log_clear    = clr;
        @(posedge mclk);
        #1;
        bus.cf_valid = 1'b0;
        log_clear    = 1'b0;
    endtask

    task automatic fill(int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 16'(16'h2000 + i), 16'(16'h3000 + i), 1'b0);
        end
    endtask

    initial begin
        puc_rst      = 1'b1;
        log_clear    = 1'b0;
        er_min       = 16'hE000;
        er_max       = 16'hE0FE;
        bus.cf_valid = 1'b0;
        bus.cf_src   = 16'h0000;
        bus.cf_dest  = 16'h0000;

        vt[0]  = mk(1, 16'h1000, 16'hE000, 0,  1, 1, 1, 0, 0, 16'h1000, 16'hE000, 16'd2);
        vt[1]  = mk(1, 16'hE010, 16'hE004, 0,  1, 1, 1, 0, 0, 16'hE010, 16'hE004, 16'd4);
        vt[2]  = mk(1, 16'hE010, 16'hE004, 0,  0, 1, 1, 0, 0, 16'hE010, 16'hE004, 16'd4);
        vt[3]  = mk(1, 16'hE010, 16'hE004, 0,  0, 1, 1, 0, 0, 16'hE010, 16'hE004, 16'd4);
        vt[4]  = mk(1, 16'hE010, 16'hE004, 0,  0, 1, 1, 0, 0, 16'hE010, 16'hE004, 16'd4);
        vt[5]  = mk(1, 16'hE010, 16'hE004, 0,  0, 1, 1, 0, 0, 16'hE010, 16'hE004, 16'd4);
        vt[6]  = mk(1, 16'hE020, 16'hE030, 0,  1, 0, 1, 0, 0, 16'hFFFF, 16'h0004, 16'd6);
        vt[7]  = mk(1, 16'h1234, 16'h5678, 0,  1, 1, 1, 0, 0, 16'hE020, 16'hE030, 16'd8);
        vt[8]  = mk(0, 16'h0000, 16'h0000, 0,  0, 1, 1, 0, 0, 16'hE020, 16'hE030, 16'd8);
        vt[9]  = mk(1, 16'hE0FE, 16'hE100, 0,  1, 1, 0, 1, 0, 16'hE0FE, 16'hE100, 16'd10);
        vt[10] = mk(1, 16'h2000, 16'hE000, 0,  0, 1, 0, 1, 0, 16'hE0FE, 16'hE100, 16'd10);
        vt[11] = mk(1, 16'h2000, 16'hE000, 1,  0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'd0);
        vt[12] = mk(1, 16'h3000, 16'hE000, 0,  1, 1, 1, 0, 0, 16'h3000, 16'hE000, 16'd2);
        vt[13] = mk(1, 16'h4000, 16'h4002, 1,  0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'd0);
        vt[14] = mk(1, 16'h5000, 16'h5002, 0,  0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'd0);
        vt[15] = mk(1, 16'hE008, 16'hE000, 0,  1, 1, 1, 0, 0, 16'hE008, 16'hE000, 16'd2);
        vt[16] = mk(1, 16'h5000, 16'hE000, 0,  1, 1, 1, 0, 0, 16'h5000, 16'hE000, 16'd4);
        vt[17] = mk(1, 16'hE010, 16'hE012, 0,  1, 1, 1, 0, 0, 16'hE010, 16'hE012, 16'd6);
        vt[18] = mk(1, 16'hE010, 16'hE012, 0,  0, 1, 1, 0, 0, 16'hE010, 16'hE012, 16'd6);
        vt[19] = mk(1, 16'hE0FE, 16'hE200, 0,  1, 0, 1, 0, 0, 16'hFFFF, 16'h0001, 16'd8);
        vt[20] = mk(0, 16'h0000, 16'h0000, 0,  1, 1, 0, 1, 0, 16'hE0FE, 16'hE200, 16'd10);
        vt[21] = mk(0, 16'h0000, 16'h0000, 0,  0, 1, 0, 1, 0, 16'hE0FE, 16'hE200, 16'd10);

        #12;
        check("reset", snap(), pack(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'd0));
        puc_rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cyc(vt[i].valid, vt[i].src, vt[i].dest, vt[i].clr);
            check($sformatf("vec%0d", i), snap(),
                  pack(vt[i].wen, vt[i].rdy, vt[i].act, vt[i].done, vt[i].ovf,
                       vt[i].esrc, vt[i].edest, vt[i].eptr));
        end

        // Fill to capacity, then distinct transfers are dropped.
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        cyc(1'b1, 16'h1000, 16'hE000, 1'b0);
        fill(63);
        check("fill_128", snap(), pack(1, 1, 1, 0, 0, 16'h203E, 16'h303E, 16'd128));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'(16'h4000 + i), 16'(16'h4100 + i), 1'b0);
            check($sformatf("full_drop%0d", i), snap(),
                  pack(0, 1, 1, 0, 1, 16'h203E, 16'h303E, 16'd128));
        end

        // Counter entry takes the last slot, pending pair is dropped.
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        check("clear_after_full", snap(), pack(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'd0));
        cyc(1'b1, 16'h1000, 16'hE000, 1'b0);
        fill(62);
        check("fill_126", snap(), pack(1, 1, 1, 0, 0, 16'h203D, 16'h303D, 16'd126));
        cyc(1'b1, 16'h203D, 16'h303D, 1'b0);
        cyc(1'b1, 16'h203D, 16'h303D, 1'b0);
        check("rep_no_wen", snap(), pack(0, 1, 1, 0, 0, 16'h203D, 16'h303D, 16'd126));
        cyc(1'b1, 16'h6000, 16'h6001, 1'b0);
        check("cnt_last_slot", snap(), pack(1, 0, 1, 0, 0, 16'hFFFF, 16'h0002, 16'd128));
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        check("pend_dropped", snap(), pack(0, 1, 1, 0, 1, 16'hFFFF, 16'h0002, 16'd128));

        // Async reset while in FLUSH discards the pending pair.
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        cyc(1'b1, 16'h1000, 16'hE000, 1'b0);
        cyc(1'b1, 16'hE010, 16'hE004, 1'b0);
        cyc(1'b1, 16'hE010, 16'hE004, 1'b0);
        cyc(1'b1, 16'hE020, 16'hE030, 1'b0);
        check("in_flush", snap(), pack(1, 0, 1, 0, 0, 16'hFFFF, 16'h0001, 16'd6));
        #2;
        puc_rst = 1'b1;
        #1;
        check("rst_in_flush", snap(), pack(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'd0));
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0);
            check($sformatf("post_rst_idle%0d", i), snap(),
                  pack(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'd0));
        end
        cyc(1'b1, 16'h1000, 16'hE000, 1'b0);
        check("post_rst_entry", snap(), pack(1, 1, 1, 0, 0, 16'h1000, 16'hE000, 16'd2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
